ahb_master_arbiter: RTL and testbench

Round-robin arbiter that shares the single AHB slave port of the AHB-to-APB bridge between up to four AHB masters. It sits in front of the bridge's AHB slave interface. It owns bus grant, the address-phase multiplexer, the data-phase (write data) multiplexer, and a locked-transfer timeout. All AHB pipelining is preserved: the address phase follows the current owner, and write data follows the owner of the previous accepted address phase.

---
 rtl/ahb_master_arbiter.sv | 143 ++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB master arbiter in front of the AHB-to-APB bridge slave port.
// Owns bus grant, the address-phase and data-phase muxes, and a bounded
// locked-transfer hold so a locking master cannot starve the others.
module ahb_master_arbiter #(
   parameter int WIDTH    = 32,
   parameter int MASTERS  = 4,
   parameter int MAX_LOCK = 16
) (
   input  logic                       Hclk,
   input  logic                       Hresetn,
   input  logic [MASTERS-1:0]         Hbusreq,
   input  logic [MASTERS-1:0]         Hlock,
   input  logic [2*MASTERS-1:0]       Htrans_m,
   input  logic [WIDTH*MASTERS-1:0]   Haddr_m,
   input  logic [MASTERS-1:0]         Hwrite_m,
   input  logic [3*MASTERS-1:0]       Hsize_m,
   input  logic [WIDTH*MASTERS-1:0]   Hwdata_m,
   input  logic                       Hreadyout,
   output logic [MASTERS-1:0]         Hgrant,
   output logic [1:0]                 Hmaster,
   output logic                       Hmastlock,
   output logic [1:0]                 Htrans,
   output logic [WIDTH-1:0]           Haddr,
   output logic                       Hwrite,
   output logic [2:0]                 Hsize,
   output logic [WIDTH-1:0]           Hwdata,
   output logic                       Hreadyin
);

   localparam int              LCW        = $clog2(MAX_LOCK + 1);
   localparam logic [LCW-1:0]  LOCK_LIMIT = LCW'(MAX_LOCK);
   localparam logic [1:0]      TRANS_IDLE = 2'b00;

   // Per-master views of the packed request buses
   logic [1:0]       trans_arr [MASTERS];
   logic [WIDTH-1:0] addr_arr  [MASTERS];
   logic [2:0]       size_arr  [MASTERS];
   logic [WIDTH-1:0] wdata_arr [MASTERS];

   genvar gi;
   generate
      for (gi = 0; gi < MASTERS; gi++) begin : g_unpack
         assign trans_arr[gi] = Htrans_m[2*gi +: 2];
         assign addr_arr[gi]  = Haddr_m[WIDTH*gi +: WIDTH];
         assign size_arr[gi]  = Hsize_m[3*gi +: 3];
         assign wdata_arr[gi] = Hwdata_m[WIDTH*gi +: WIDTH];
      end
   endgenerate

   // Ownership state
   logic [MASTERS-1:0] grant_q, grant_d;
   logic [1:0]         hmaster_q, hmaster_d;
   logic [1:0]         data_owner_q, data_owner_d;
   logic [LCW-1:0]     lock_cnt_q, lock_cnt_d;

   // Decode helpers
   logic       busreq_own;
   logic       lock_own;
   logic       others_req;
   logic       lock_hold;
   logic       boundary;
   logic       owner_change;
   logic [1:0] rr_pick;
   logic       rr_found;
   logic [2:0] cand;

   assign busreq_own = Hbusreq[hmaster_q];
   assign lock_own   = Hlock[hmaster_q];
   assign others_req = |(Hbusreq & ~grant_q);
   assign lock_hold  = lock_own && (lock_cnt_q < LOCK_LIMIT);
   assign boundary   = Hreadyout
                       && ((trans_arr[hmaster_q] == TRANS_IDLE) || !busreq_own)
                       && !lock_hold;

   // Round-robin search: first requester after the owner, wrapping back to the owner
   always_comb begin
      rr_pick  = 2'd0;
      rr_found = 1'b0;
      cand     = 3'd0;
      for (int k = 1; k <= MASTERS; k++) begin
         cand = {1'b0, hmaster_q} + 3'(k);
         if (cand >= 3'(MASTERS)) begin
            cand = cand - 3'(MASTERS);
         end
         if (!rr_found && Hbusreq[cand[1:0]]) begin
            rr_found = 1'b1;
            rr_pick  = cand[1:0];
         end
      end
   end

   // Next owner, data-phase owner and lock counter
   always_comb begin
      hmaster_d    = hmaster_q;
      data_owner_d = data_owner_q;
      lock_cnt_d   = lock_cnt_q;
      grant_d      = '0;

      if (boundary) begin
         // With nobody asking the bus parks on master 0
         hmaster_d = rr_found ? rr_pick : 2'd0;
      end
      grant_d[hmaster_d] = 1'b1;

      // Write data follows whoever owned the address phase just accepted
      if (Hreadyout) begin
         data_owner_d = hmaster_q;
      end

      owner_change = (hmaster_d != hmaster_q);
      if (owner_change || !lock_own) begin
         lock_cnt_d = '0;
      end else if (others_req && (lock_cnt_q != LOCK_LIMIT)) begin
         lock_cnt_d = lock_cnt_q + LCW'(1);
      end
   end

   // State registers; reset parks the bus on master 0 without any flush
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         grant_q      <= MASTERS'(1);
         hmaster_q    <= 2'd0;
         data_owner_q <= 2'd0;
         lock_cnt_q   <= '0;
      end else begin
         grant_q      <= grant_d;
         hmaster_q    <= hmaster_d;
         data_owner_q <= data_owner_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   assign Hgrant    = grant_q;
   assign Hmaster   = hmaster_q;
   assign Hmastlock = lock_own && (lock_cnt_q != LOCK_LIMIT);
   assign Htrans    = trans_arr[hmaster_q];
   assign Haddr     = addr_arr[hmaster_q];
   assign Hwrite    = Hwrite_m[hmaster_q];
   assign Hsize     = size_arr[hmaster_q];
   assign Hwdata    = wdata_arr[data_owner_q];
   assign Hreadyin  = Hreadyout;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: vector table of per-cycle inputs and expected
// owner / data owner / lock flag, checked through a scoreboard queue.
module tb_ahb_master_arbiter;

   localparam int WIDTH    = 32;
   localparam int MASTERS  = 4;
   localparam int MAX_LOCK = 16;

   logic                     Hclk = 1'b0;
   logic                     Hresetn = 1'b1;
   logic [MASTERS-1:0]       Hbusreq;
   logic [MASTERS-1:0]       Hlock;
   logic [2*MASTERS-1:0]     Htrans_m;
   logic [WIDTH*MASTERS-1:0] Haddr_m;
   logic [MASTERS-1:0]       Hwrite_m;
   logic [3*MASTERS-1:0]     Hsize_m;
   logic [WIDTH*MASTERS-1:0] Hwdata_m;
   logic                     Hreadyout;
   logic [MASTERS-1:0]       Hgrant;
   logic [1:0]               Hmaster;
   logic                     Hmastlock;
   logic [1:0]               Htrans;
   logic [WIDTH-1:0]         Haddr;
   logic                     Hwrite;
   logic [2:0]               Hsize;
   logic [WIDTH-1:0]         Hwdata;
   logic                     Hreadyin;

   ahb_master_arbiter #(.WIDTH(WIDTH), .MASTERS(MASTERS), .MAX_LOCK(MAX_LOCK)) dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .Hbusreq   (Hbusreq),
      .Hlock     (Hlock),
      .Htrans_m  (Htrans_m),
      .Haddr_m   (Haddr_m),
      .Hwrite_m  (Hwrite_m),
      .Hsize_m   (Hsize_m),
      .Hwdata_m  (Hwdata_m),
      .Hreadyout (Hreadyout),
      .Hgrant    (Hgrant),
      .Hmaster   (Hmaster),
      .Hmastlock (Hmastlock),
      .Htrans    (Htrans),
      .Haddr     (Haddr),
      .Hwrite    (Hwrite),
      .Hsize     (Hsize),
      .Hwdata    (Hwdata),
      .Hreadyin  (Hreadyin)
   );

   always #5 Hclk = ~Hclk;

   typedef struct {
      logic [3:0] busreq;
      logic [3:0] lock;
      logic [7:0] trans;
      logic       ready;
      logic [1:0] m;     // expected owner during this cycle
      logic [1:0] d;     // expected data-phase owner during this cycle
      logic       ml;    // expected Hmastlock
   } vec_t;

   typedef struct {
      logic [3:0]  grant;
      logic [1:0]  master;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic        mastlock;
      logic        readyin;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   function automatic void add(input logic [3:0] busreq, input logic [3:0] lock,
                               input logic [7:0] trans, input logic ready,
                               input logic [1:0] m, input logic [1:0] d, input logic ml);
      vec_t v;
      v.busreq = busreq; v.lock = lock; v.trans = trans; v.ready = ready;
      v.m = m; v.d = d; v.ml = ml;
      vecs.push_back(v);
   endfunction

   function automatic exp_t mk_exp(input vec_t v);
      exp_t e;
      e.grant    = 4'b0001 << v.m;
      e.master   = v.m;
      e.addr     = 32'hA000_0000 + 32'(v.m) * 32'h100;
      e.trans    = v.trans[2*v.m +: 2];
      e.write    = Hwrite_m[v.m];
      e.size     = {1'b0, v.m};
      e.wdata    = 32'hD000_0000 + 32'(v.d);
      e.mastlock = v.ml;
      e.readyin  = v.ready;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s actual=%h expected=%h", step_no, name, act, exp);
      end
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL step %0d scoreboard_empty actual=0 expected=1", step_no);
         return;
      end
      e = sb.pop_front();
      chk("Hgrant",    32'(Hgrant),    32'(e.grant));
      chk("Hmaster",   32'(Hmaster),   32'(e.master));
      chk("Haddr",     Haddr,          e.addr);
      chk("Htrans",    32'(Htrans),    32'(e.trans));
      chk("Hwrite",    32'(Hwrite),    32'(e.write));
      chk("Hsize",     32'(Hsize),     32'(e.size));
      chk("Hwdata",    Hwdata,         e.wdata);
      chk("Hmastlock", 32'(Hmastlock), 32'(e.mastlock));
      chk("Hreadyin",  32'(Hreadyin),  32'(e.readyin));
      $display("step %0d req=%b lock=%b rdy=%b grant=%b master=%0d wdata=%h mastlock=%b",
               step_no, Hbusreq, Hlock, Hreadyout, Hgrant, Hmaster, Hwdata, Hmastlock);
      step_no++;
   endtask

   task automatic drive(input vec_t v);
      Hbusreq   = v.busreq;
      Hlock     = v.lock;
      Htrans_m  = v.trans;
      Hreadyout = v.ready;
   endtask

   // Drive one cycle's inputs, then compare mid-cycle on the falling edge
   task automatic apply_check(input vec_t v);
      drive(v);
      sb.push_back(mk_exp(v));
      @(negedge Hclk);
      compare_out();
   endtask

   task automatic step(input vec_t v);
      apply_check(v);
      @(posedge Hclk);
      #1;
   endtask

   task automatic step_args(input logic [3:0] busreq, input logic [3:0] lock,
                            input logic [7:0] trans, input logic ready,
                            input logic [1:0] m, input logic [1:0] d, input logic ml);
      vec_t v;
      v.busreq = busreq; v.lock = lock; v.trans = trans; v.ready = ready;
      v.m = m; v.d = d; v.ml = ml;
      step(v);
   endtask

   initial begin
      vec_t vr;

      for (int i = 0; i < MASTERS; i++) begin
         Haddr_m[WIDTH*i +: WIDTH]  = 32'hA000_0000 + 32'(i) * 32'h100;
         Hwdata_m[WIDTH*i +: WIDTH] = 32'hD000_0000 + 32'(i);
         Hsize_m[3*i +: 3]          = 3'(i);
      end
      Hwrite_m  = 4'b1010;
      Hbusreq   = '0;
      Hlock     = 4'b0001;
      Htrans_m  = '0;
      Hreadyout = 1'b1;

      // Round robin 1,2,3 from park, single NONSEQ each, data owner lags one cycle
      add(4'b1110, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      add(4'b1110, 4'b0000, 8'h08, 1'b1, 2'd1, 2'd0, 1'b0);
      add(4'b1100, 4'b0000, 8'h00, 1'b1, 2'd1, 2'd1, 1'b0);
      add(4'b1100, 4'b0000, 8'h20, 1'b1, 2'd2, 2'd1, 1'b0);
      add(4'b1000, 4'b0000, 8'h00, 1'b1, 2'd2, 2'd2, 1'b0);
      add(4'b1000, 4'b0000, 8'h80, 1'b1, 2'd3, 2'd2, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd3, 2'd3, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd3, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      // Master 2 burst NONSEQ,SEQ,BUSY,SEQ,SEQ with master 0 waiting
      add(4'b0100, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      add(4'b0101, 4'b0000, 8'h20, 1'b1, 2'd2, 2'd0, 1'b0);
      add(4'b0101, 4'b0000, 8'h30, 1'b1, 2'd2, 2'd2, 1'b0);
      add(4'b0101, 4'b0000, 8'h10, 1'b1, 2'd2, 2'd2, 1'b0);
      add(4'b0101, 4'b0000, 8'h30, 1'b1, 2'd2, 2'd2, 1'b0);
      add(4'b0001, 4'b0000, 8'h30, 1'b1, 2'd2, 2'd2, 1'b0);
      add(4'b0001, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd2, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      // Hreadyout low for 3 cycles across a handover boundary
      add(4'b0010, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) add(4'b1000, 4'b0000, 8'h00, 1'b0, 2'd1, 2'd0, 1'b0);
      add(4'b1000, 4'b0000, 8'h00, 1'b1, 2'd1, 2'd0, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd3, 2'd1, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd3, 1'b0);
      // Master 1 locks: alone it keeps the bus, with master 3 waiting it gets 16 cycles
      add(4'b0010, 4'b0010, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      for (int i = 0; i < 20; i++)
         add(4'b0010, 4'b0010, 8'h00, 1'b1, 2'd1, (i == 0) ? 2'd0 : 2'd1, 1'b1);
      for (int i = 0; i < MAX_LOCK; i++)
         add(4'b1010, 4'b0010, 8'h00, 1'b1, 2'd1, 2'd1, 1'b1);
      add(4'b1010, 4'b0010, 8'h00, 1'b1, 2'd1, 2'd1, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd3, 2'd1, 1'b0);
      add(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd3, 1'b0);

      // Asynchronous reset with Hlock[0] high, then low
      vr.busreq = 4'b0000; vr.lock = 4'b0001; vr.trans = 8'h00; vr.ready = 1'b1;
      vr.m = 2'd0; vr.d = 2'd0; vr.ml = 1'b1;
      #1 Hresetn = 1'b0;
      #2;
      sb.push_back(mk_exp(vr));
      compare_out();
      vr.lock = 4'b0000; vr.ml = 1'b0;
      drive(vr);
      #1;
      sb.push_back(mk_exp(vr));
      compare_out();
      @(negedge Hclk);
      Hresetn = 1'b1;
      @(posedge Hclk);
      #1;

      foreach (vecs[i]) step(vecs[i]);

      // Reset while master 3 owns mid-burst
      step_args(4'b1000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      step_args(4'b1000, 4'b1000, 8'h80, 1'b1, 2'd3, 2'd0, 1'b1);
      vr.busreq = 4'b1000; vr.lock = 4'b1000; vr.trans = 8'hC0; vr.ready = 1'b1;
      vr.m = 2'd3; vr.d = 2'd3; vr.ml = 1'b1;
      apply_check(vr);
      #2 Hresetn = 1'b0;
      #1;
      vr.m = 2'd0; vr.d = 2'd0; vr.ml = 1'b0;
      sb.push_back(mk_exp(vr));
      compare_out();
      @(posedge Hclk);
      #1;
      sb.push_back(mk_exp(vr));
      compare_out();
      vr.busreq = 4'b0000; vr.lock = 4'b0000; vr.trans = 8'h00;
      drive(vr);
      @(negedge Hclk);
      Hresetn = 1'b1;
      @(posedge Hclk);
      #1;
      step_args(4'b1000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
      step_args(4'b1000, 4'b0000, 8'h80, 1'b1, 2'd3, 2'd0, 1'b0);
      step_args(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd3, 2'd3, 1'b0);
      step_args(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd0, 2'd3, 1'b0);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
